// File: rtl/ncc_pkg.sv
// ncc_pkg: shared constants and types for the NCC descriptor-load path.
//   DESC_PIXELS / PE_ROWS / COL_GROUPS / PIX_W : descriptor geometry
//   desc_word_t : one packed descriptor word (4 pixels)
//   tx_state_t  : descriptor transmitter FSM states
package ncc_pkg;

    localparam int DESC_PIXELS = 256;
    localparam int PE_ROWS     = 16;
    localparam int COL_GROUPS  = 4;
    localparam int PIX_W       = 8;

    typedef logic [31:0] desc_word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/word_fifo.sv
// word_fifo: small synchronous FIFO of packed descriptor words.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   flush       synchronously empties the FIFO
//   push        write push_data (ignored when full)
//   push_data   word to write
//   pop         drop the head word (ignored when empty)
//   head        current head word (valid while ~empty)
//   full, empty occupancy flags
// DEPTH must be a power of 2 and >= 2; pointers carry one extra wrap bit so
// full and empty are distinguishable without an occupancy counter.
module word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Storage carries no reset; stale entries are never visible because
    // head is only meaningful while the pointers say non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    // Head is read straight from the array so a pushed word is presentable
    // one cycle after the push.
    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/desc_stream_tx.sv
// desc_stream_tx: transmit side of the NCC descriptor-load interface.
// Packs 8-bit pixels 4-per-word (first pixel in the top byte), buffers the
// words and hands them one at a time to the PE-grid loader.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            begin one descriptor (honoured in IDLE only)
//   pix_in/pix_valid/pix_ready   pixel stream, accepted on valid & ready
//   desc_data_out    head word for the loader (0 while nothing is offered)
//   desc_data_ready  a valid, unconsumed word is on desc_data_out
//   desc_ack         loader consumed the offered word
//   word_count       words acknowledged so far in this descriptor
//   busy             transfer in progress (state != IDLE)
//   desc_done        one-cycle pulse after the last word is acknowledged
module desc_stream_tx #(
    parameter int PIX_W      = ncc_pkg::PIX_W,
    parameter int WORDS      = ncc_pkg::PE_ROWS * ncc_pkg::COL_GROUPS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [PIX_W-1:0]           pix_in,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic [4*PIX_W-1:0]         desc_data_out,
    output logic                       desc_data_ready,
    input  logic                       desc_ack,
    output logic [$clog2(WORDS)-1:0]   word_count,
    output logic                       busy,
    output logic                       desc_done
);

    import ncc_pkg::*;

    localparam int WORD_W = 4 * PIX_W;
    localparam int WC_W   = $clog2(WORDS);
    localparam int PC_W   = $clog2(WORDS * 4);

    tx_state_t               state_reg;
    logic [1:0]              pack_cnt_reg;
    logic [PC_W-1:0]         pix_cnt_reg;
    logic [WC_W-1:0]         word_count_reg;
    // Lane 0 is never stored: the 4th pixel goes straight into the FIFO.
    logic [WORD_W-1:PIX_W]   pack_reg;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [WORD_W-1:0]       fifo_head;
    logic                    fifo_flush;
    logic                    pix_accept;
    logic                    word_push;
    logic                    word_pop;
    logic                    last_pix;
    logic                    last_word;

    // Only the completing pixel needs a free slot; a same-cycle pop is not
    // counted as freeing one, so pix_ready never depends on desc_ack.
    assign pix_ready       = (state_reg == STREAM) & ~((pack_cnt_reg == 2'd3) & fifo_full);
    assign pix_accept      = pix_valid & pix_ready;
    assign word_push       = pix_accept & (pack_cnt_reg == 2'd3);
    assign desc_data_ready = ~fifo_empty & ((state_reg == STREAM) | (state_reg == DRAIN));
    assign word_pop        = desc_ack & desc_data_ready;
    assign fifo_flush      = (state_reg == IDLE) & start;
    assign last_pix        = (pix_cnt_reg == PC_W'(WORDS * 4 - 1));
    assign last_word       = (word_count_reg == WC_W'(WORDS - 1));

    assign desc_data_out   = desc_data_ready ? fifo_head : '0;
    assign word_count      = word_count_reg;
    assign busy            = (state_reg != IDLE);
    assign desc_done       = (state_reg == DONE);

    word_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (word_push),
        .push_data ({pack_reg, pix_in}),
        .pop       (word_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pixel k of a word lands in byte lane 3-k.
    for (genvar gi = 1; gi < 4; gi++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pack_reg[gi*PIX_W +: PIX_W] <= '0;
            end else if (fifo_flush) begin
                pack_reg[gi*PIX_W +: PIX_W] <= '0;
            end else if (pix_accept && (pack_cnt_reg == 2'(3 - gi))) begin
                pack_reg[gi*PIX_W +: PIX_W] <= pix_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            pack_cnt_reg   <= '0;
            pix_cnt_reg    <= '0;
            word_count_reg <= '0;
        end else begin
            // word_count wraps to 0 on the final ack, as the FSM enters DONE.
            if (word_pop) word_count_reg <= word_count_reg + WC_W'(1);

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg      <= STREAM;
                        pack_cnt_reg   <= '0;
                        pix_cnt_reg    <= '0;
                        word_count_reg <= '0;
                    end
                end
                STREAM: begin
                    if (pix_accept) begin
                        pack_cnt_reg <= pack_cnt_reg + 2'd1;
                        pix_cnt_reg  <= pix_cnt_reg + PC_W'(1);
                        if (last_pix) state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (word_pop && last_word) state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_desc_stream_tx.sv
// tb_desc_stream_tx: randomized self-checking bench for desc_stream_tx.
// The reference model keeps the descriptor as plain queues: accepted pixels
// are grouped four at a time into words, words wait in a queue until the
// loader acknowledges them, and every output is predicted from those counts.
module tb_desc_stream_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] desc_data_out;
    logic        desc_data_ready;
    logic        desc_ack;
    logic [5:0]  word_count;
    logic        busy;
    logic        desc_done;

    desc_stream_tx dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .pix_in          (pix_in),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .desc_data_out   (desc_data_out),
        .desc_data_ready (desc_data_ready),
        .desc_ack        (desc_ack),
        .word_count      (word_count),
        .busy            (busy),
        .desc_done       (desc_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference model: 0 idle, 1 transfer in progress, 2 done-pulse cycle
    int          m_phase;
    int          m_acc;
    int          m_acked;
    logic [31:0] m_q[$];
    logic [7:0]  m_grp[$];
    int          done_pulses;

    // Decisions taken at a negedge, applied to the model after the posedge
    bit          pend_start, pend_acc, pend_pop;
    logic [7:0]  pend_pix;

    // Stimulus policy
    int          ack_mode;     // 0: ack 2 cycles into ready, 1: always, 2: random, 3: never
    int          valid_mode;   // 0: always, 1: random
    bit          seq_pix;      // pixels 0,1,2.. instead of random values
    bit          start_noise;  // stray start pulses during a transfer
    bit          want_start;
    int          ready_age;
    logic [7:0]  next_pix;
    logic [31:0] first_word_dut;

    function automatic logic [7:0] pick_pix(input int idx);
        logic [7:0] v;
        v = seq_pix ? 8'(idx) : 8'($urandom);
        return v;
    endfunction

    task automatic model_clear();
        m_phase = 0; m_acc = 0; m_acked = 0;
        m_q.delete(); m_grp.delete();
        pend_start = 0; pend_acc = 0; pend_pop = 0;
        ready_age = 0;
    endtask

    // One clock: apply last cycle's decisions, check outputs, drive inputs.
    task automatic tick();
        logic [31:0] w;
        bit exp_rdy, exp_prdy;
        @(negedge clk);
        if (m_phase == 2) m_phase = 0;
        if (pend_start) begin
            m_phase = 1; m_acc = 0; m_acked = 0;
            m_q.delete(); m_grp.delete();
            next_pix = pick_pix(0);
        end
        if (pend_pop) begin
            w = m_q.pop_front();
            m_acked++;
            $display("word %0d acked data=%08h", m_acked - 1, w);
            if (m_acked == 64) m_phase = 2;
        end
        if (pend_acc) begin
            m_grp.push_back(pend_pix);
            m_acc++;
            if (m_grp.size() == 4) begin
                w = {m_grp[0], m_grp[1], m_grp[2], m_grp[3]};
                m_q.push_back(w);
                m_grp.delete();
            end
            next_pix = pick_pix(m_acc);
        end

        exp_rdy  = (m_q.size() != 0);
        exp_prdy = (m_phase == 1) && (m_acc < 256) && !((m_acc % 4 == 3) && (m_q.size() == 4));
        if (desc_done === 1'b1) done_pulses++;
        expect_eq("desc_data_ready", 32'(desc_data_ready), 32'(exp_rdy));
        if (exp_rdy) expect_eq("desc_data_out", desc_data_out, m_q[0]);
        expect_eq("pix_ready", 32'(pix_ready), 32'(exp_prdy));
        expect_eq("word_count", 32'(word_count), 32'(m_acked % 64));
        expect_eq("busy", 32'(busy), 32'(m_phase != 0));
        expect_eq("desc_done", 32'(desc_done), 32'(m_phase == 2));

        start = want_start || (start_noise && m_phase == 1 && $urandom_range(0, 7) == 0);
        pix_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        pix_in = pix_valid ? next_pix : 8'($urandom);
        if (exp_rdy) ready_age++; else ready_age = 0;
        case (ack_mode)
            0:       desc_ack = (ready_age >= 3);
            1:       desc_ack = 1'b1;
            2:       desc_ack = 1'($urandom_range(0, 1));
            default: desc_ack = 1'b0;
        endcase
        pend_start = start && (m_phase == 0);
        pend_acc   = pix_valid && exp_prdy;
        pend_pix   = pix_in;
        pend_pop   = desc_ack && exp_rdy;
        if (pend_pop) ready_age = 0;
        if (pend_pop && m_acked == 0) first_word_dut = desc_data_out;
    endtask

    task automatic start_desc();
        done_pulses = 0;
        want_start = 1'b1;
        tick();
        want_start = 1'b0;
    endtask

    task automatic finish_desc(input string tag);
        int n;
        n = 0;
        while ((m_phase != 0 || pend_start) && n < 4000) begin
            tick();
            n++;
        end
        expect_eq({tag, "_completed"}, 32'(n < 4000), 32'd1);
        expect_eq({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        expect_eq({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
        expect_eq({tag, "_data_ready"}, 32'(desc_data_ready), 32'd0);
        expect_eq({tag, "_data_out"}, desc_data_out, 32'd0);
        expect_eq({tag, "_word_count"}, 32'(word_count), 32'd0);
        expect_eq({tag, "_busy"}, 32'(busy), 32'd0);
        expect_eq({tag, "_done"}, 32'(desc_done), 32'd0);
    endtask

    task automatic quiet_inputs();
        start = 1'b0; pix_valid = 1'b0; pix_in = 8'd0; desc_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        want_start = 0; start_noise = 0; seq_pix = 1; ack_mode = 0; valid_mode = 0;
        next_pix = 8'd0; first_word_dut = 32'd0; done_pulses = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // pix_valid while idle must be ignored
        valid_mode = 0; ack_mode = 1;
        repeat (5) tick();

        // 1: sequential pixels, ack 2 cycles into each ready
        seq_pix = 1; valid_mode = 0; ack_mode = 0;
        start_desc();
        finish_desc("seq_desc");
        tick();
        expect_eq("busy_after_done", 32'(busy), 32'd0);

        // 2: loader stalls while the stream keeps offering pixels
        seq_pix = 1; valid_mode = 0; ack_mode = 3;
        start_desc();
        repeat (40) tick();
        expect_eq("stall_pix_ready", 32'(pix_ready), 32'd0);
        expect_eq("stall_head", desc_data_out, 32'h00010203);
        expect_eq("stall_data_ready", 32'(desc_data_ready), 32'd1);
        expect_eq("stall_word_count", 32'(word_count), 32'd0);
        ack_mode = 0;
        finish_desc("stall_desc");

        // 3: ack held high, gaps in the pixel stream, random pixels
        seq_pix = 0; valid_mode = 1; ack_mode = 1;
        start_desc();
        finish_desc("ack_high_desc");

        // 4: random ack and valid; pushes and pops collide at mid occupancy
        seq_pix = 0; valid_mode = 1; ack_mode = 2; start_noise = 1;
        start_desc();
        finish_desc("random_desc");

        // 5: reset after 100 pixels, then a clean descriptor
        seq_pix = 1; valid_mode = 0; ack_mode = 2; start_noise = 0;
        start_desc();
        while (m_acc < 100) tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        quiet_inputs();
        model_clear();
        seq_pix = 1; valid_mode = 0; ack_mode = 0;
        start_desc();
        finish_desc("post_reset_desc");
        expect_eq("post_reset_first_word", first_word_dut, 32'h00010203);

        // 6: stray start pulses and pix_valid in drain on a random descriptor
        seq_pix = 0; valid_mode = 0; ack_mode = 2; start_noise = 1;
        start_desc();
        finish_desc("stray_start_desc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
